disp_cfg_sequencer: RTL and testbench

Frame-synchronous configuration sequencer for the character display path. It accepts colour, size, offset and flash commands over a valid/ready handshake into shadow registers. It commits them atomically to the live outputs only at the start of vertical sync, so a setting never changes mid-frame. It also generates the character flash clock from a frame counter. Its outputs drive the display controller's charRGB, bgRGB, charSize, charOffset and flashClk inputs directly; its vSync input is the display's vertical sync.

---
 rtl/disp_cfg_sequencer.sv | 161 ++++++++++++++++
 tb/tb_disp_cfg_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_cfg_sequencer.sv
// Purpose: frame-synchronous display config sequencer; shadow regs written over valid/ready, committed to live outputs at vSync start; flash clock from a frame counter.
// Latency: shadow written at the accepting edge; live outputs change 2 cycles after vSync is sampled asserted (frameTick, then COMMIT).
// Backpressure: cmdReady is low from an accepted COMMIT request until the commit lands; commands offered meanwhile stay unaccepted.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   vSync                 vertical sync, polarity set by VSYNC_ACTIVE_LOW
//   cmdValid/cmdReady     command handshake; cmdOp (3b) + cmdData (9b) payload
//   pending               commit requested but not yet applied
//   charRGB, bgRGB        live foreground/background colour (9b)
//   charSize, charOffset  live character scale/offset (4b)
//   flashClk              flash phase for the character renderer
module disp_cfg_sequencer #(
    parameter int unsigned FLASH_FRAMES     = 30,
    parameter logic        VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       vSync,
    input  logic       cmdValid,
    input  logic [2:0] cmdOp,
    input  logic [8:0] cmdData,
    output logic       cmdReady,
    output logic       pending,
    output logic [8:0] charRGB,
    output logic [8:0] bgRGB,
    output logic [3:0] charSize,
    output logic [3:0] charOffset,
    output logic       flashClk
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [5:0] LAST_FRAME = 6'(FLASH_FRAMES - 1);

    localparam logic [8:0] RST_CHAR_RGB = 9'h1FF;
    localparam logic [8:0] RST_BG_RGB   = 9'h000;
    localparam logic [3:0] RST_SIZE     = 4'd1;
    localparam logic [3:0] RST_OFFSET   = 4'd0;

    logic [1:0] state;
    logic [1:0] stateNext;

    // vSync normalised so that 1 always means "asserted".
    logic vSyncAsserted;
    logic vSyncSample;
    logic vSyncPrev;
    logic frameTick;

    logic [8:0] shCharRGB;
    logic [8:0] shBgRGB;
    logic [3:0] shCharSize;
    logic [3:0] shCharOffset;
    logic       shFlashEn;
    logic       liveFlashEn;
    logic [5:0] frameCount;
    logic       cmdAccept;

    assign vSyncAsserted = vSync ^ VSYNC_ACTIVE_LOW;
    assign frameTick     = vSyncSample & ~vSyncPrev;

    assign cmdReady  = (state == IDLE);
    assign pending   = (state == ARMED) || (state == COMMIT);
    assign cmdAccept = cmdValid & cmdReady;

    // History resets to "deasserted" so leaving reset never fakes a frame start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vSyncSample <= 1'b0;
            vSyncPrev   <= 1'b0;
        end else begin
            vSyncSample <= vSyncAsserted;
            vSyncPrev   <= vSyncSample;
        end
    end

    // A tick seen while IDLE (including the cycle a COMMIT request is accepted)
    // is ignored, so a request always waits for the next frame.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (cmdAccept && cmdOp == 3'd6) stateNext = ARMED;
            ARMED:   if (frameTick) stateNext = COMMIT;
            COMMIT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Shadow registers: only writable while IDLE, hence frozen while a commit is pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shCharRGB    <= RST_CHAR_RGB;
            shBgRGB      <= RST_BG_RGB;
            shCharSize   <= RST_SIZE;
            shCharOffset <= RST_OFFSET;
            shFlashEn    <= 1'b0;
        end else if (cmdAccept) begin
            case (cmdOp)
                3'd1: shCharRGB    <= cmdData;
                3'd2: shBgRGB      <= cmdData;
                3'd3: shCharSize   <= (cmdData[3:0] == 4'd0) ? 4'd1 : cmdData[3:0];
                3'd4: shCharOffset <= cmdData[3:0];
                3'd5: shFlashEn    <= cmdData[0];
                3'd7: begin
                    shCharRGB    <= RST_CHAR_RGB;
                    shBgRGB      <= RST_BG_RGB;
                    shCharSize   <= RST_SIZE;
                    shCharOffset <= RST_OFFSET;
                    shFlashEn    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Live registers move only on the COMMIT edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            charRGB     <= RST_CHAR_RGB;
            bgRGB       <= RST_BG_RGB;
            charSize    <= RST_SIZE;
            charOffset  <= RST_OFFSET;
            liveFlashEn <= 1'b0;
        end else if (state == COMMIT) begin
            charRGB     <= shCharRGB;
            bgRGB       <= shBgRGB;
            charSize    <= shCharSize;
            charOffset  <= shCharOffset;
            liveFlashEn <= shFlashEn;
        end
    end

    // Flash generator. Disabling takes effect on the commit edge itself; while
    // disabled the counter and phase sit at 0, so re-enabling starts clean.
    // A frameTick can never coincide with the COMMIT cycle (vSync was just
    // asserted), so the two branches never compete.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frameCount <= 6'd0;
            flashClk   <= 1'b0;
        end else if ((state == COMMIT && !shFlashEn) || !liveFlashEn) begin
            frameCount <= 6'd0;
            flashClk   <= 1'b0;
        end else if (frameTick) begin
            if (frameCount == LAST_FRAME) begin
                frameCount <= 6'd0;
                flashClk   <= ~flashClk;
            end else begin
                frameCount <= frameCount + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_disp_cfg_sequencer.sv
module tb_disp_cfg_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       vSync;
    logic       cmdValid;
    logic [2:0] cmdOp;
    logic [8:0] cmdData;
    logic       cmdReady;
    logic       pending;
    logic [8:0] charRGB;
    logic [8:0] bgRGB;
    logic [3:0] charSize;
    logic [3:0] charOffset;
    logic       flashClk;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [2:0] op;
        logic [8:0] data;
        logic [8:0] eChar;
        logic [8:0] eBg;
        logic [3:0] eSize;
        logic [3:0] eOff;
    } vec_t;

    vec_t vecs[10];
    logic flashExp[8];

    disp_cfg_sequencer #(
        .FLASH_FRAMES(2),
        .VSYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .vSync(vSync),
        .cmdValid(cmdValid),
        .cmdOp(cmdOp),
        .cmdData(cmdData),
        .cmdReady(cmdReady),
        .pending(pending),
        .charRGB(charRGB),
        .bgRGB(bgRGB),
        .charSize(charSize),
        .charOffset(charOffset),
        .flashClk(flashClk)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkLive(input string tag, input logic [8:0] c, input logic [8:0] b,
                             input logic [3:0] s, input logic [3:0] o);
        check({tag, " charRGB"}, 32'(charRGB), 32'(c));
        check({tag, " bgRGB"}, 32'(bgRGB), 32'(b));
        check({tag, " charSize"}, 32'(charSize), 32'(s));
        check({tag, " charOffset"}, 32'(charOffset), 32'(o));
    endtask

    // Offer a command and hold it until the accepting edge (bounded wait).
    task automatic sendCmd(input logic [2:0] op, input logic [8:0] data);
        int waited;
        waited   = 0;
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdData  = data;
        while (!cmdReady && waited < 100) begin
            tick();
            waited++;
        end
        check("cmd accepted", 32'(cmdReady), 32'd1);
        tick();
        cmdValid = 1'b0;
    endtask

    // One short frame: vSync asserted (low) for 2 cycles, then 6 deasserted.
    task automatic frame();
        vSync = 1'b0;
        tick();
        tick();
        vSync = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        vecs[0] = '{3'd3, 9'h000, 9'h0A5, 9'h038, 4'd1, 4'd0};
        vecs[1] = '{3'd6, 9'h000, 9'h0A5, 9'h038, 4'd1, 4'd0};
        vecs[2] = '{3'd3, 9'h00F, 9'h0A5, 9'h038, 4'd1, 4'd0};
        vecs[3] = '{3'd4, 9'h009, 9'h0A5, 9'h038, 4'd1, 4'd0};
        vecs[4] = '{3'd6, 9'h000, 9'h0A5, 9'h038, 4'hF, 4'd9};
        vecs[5] = '{3'd3, 9'h000, 9'h0A5, 9'h038, 4'hF, 4'd9};
        vecs[6] = '{3'd6, 9'h000, 9'h0A5, 9'h038, 4'd1, 4'd9};
        vecs[7] = '{3'd2, 9'h1C7, 9'h0A5, 9'h038, 4'd1, 4'd9};
        vecs[8] = '{3'd7, 9'h000, 9'h0A5, 9'h038, 4'd1, 4'd9};
        vecs[9] = '{3'd6, 9'h000, 9'h1FF, 9'h000, 4'd1, 4'd0};
        flashExp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        reset    = 1'b1;
        vSync    = 1'b1;
        cmdValid = 1'b0;
        cmdOp    = 3'd0;
        cmdData  = 9'd0;
        repeat (3) tick();

        // Reset state, then idle frames leave it untouched.
        checkLive("reset", 9'h1FF, 9'h000, 4'd1, 4'd0);
        check("reset cmdReady", 32'(cmdReady), 32'd1);
        check("reset pending", 32'(pending), 32'd0);
        check("reset flashClk", 32'(flashClk), 32'd0);
        reset = 1'b0;
        frame();
        frame();
        checkLive("idle frames", 9'h1FF, 9'h000, 4'd1, 4'd0);
        check("idle flashClk", 32'(flashClk), 32'd0);
        check("idle pending", 32'(pending), 32'd0);

        // Uncommitted writes stay invisible; then exact commit latency.
        sendCmd(3'd1, 9'h0A5);
        sendCmd(3'd2, 9'h038);
        repeat (3) frame();
        checkLive("no commit", 9'h1FF, 9'h000, 4'd1, 4'd0);
        sendCmd(3'd6, 9'h000);
        check("armed pending", 32'(pending), 32'd1);
        check("armed cmdReady", 32'(cmdReady), 32'd0);
        vSync = 1'b0;
        tick();  // E0
        check("E0 charRGB", 32'(charRGB), 32'h1FF);
        tick();  // E1
        check("E1 charRGB", 32'(charRGB), 32'h1FF);
        check("E1 pending", 32'(pending), 32'd1);
        check("E1 cmdReady", 32'(cmdReady), 32'd0);
        tick();  // E2
        checkLive("E2", 9'h0A5, 9'h038, 4'd1, 4'd0);
        check("E2 pending", 32'(pending), 32'd0);
        check("E2 cmdReady", 32'(cmdReady), 32'd1);
        vSync = 1'b1;
        repeat (6) tick();

        // Table-driven: each command followed by one frame.
        for (int i = 0; i < 10; i++) begin
            sendCmd(vecs[i].op, vecs[i].data);
            frame();
            checkLive($sformatf("vec%0d", i), vecs[i].eChar, vecs[i].eBg,
                      vecs[i].eSize, vecs[i].eOff);
            check($sformatf("vec%0d pending", i), 32'(pending), 32'd0);
        end

        // Flash with FLASH_FRAMES=2, sampled before each frame's vSync.
        sendCmd(3'd5, 9'h001);
        sendCmd(3'd6, 9'h000);
        frame();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) check($sformatf("flash frame%0d", i), 32'(flashClk), 32'(flashExp[i]));
            frame();
        end
        check("flash before disable", 32'(flashClk), 32'd1);
        sendCmd(3'd5, 9'h000);
        sendCmd(3'd6, 9'h000);
        vSync = 1'b0;
        tick();
        tick();  // E1: counter advances, phase unchanged
        check("disable E1 flashClk", 32'(flashClk), 32'd1);
        tick();  // E2: commit clears phase
        check("disable E2 flashClk", 32'(flashClk), 32'd0);
        vSync = 1'b1;
        repeat (6) tick();
        frame();
        frame();
        check("disabled flashClk", 32'(flashClk), 32'd0);

        // COMMIT request in the frameTick cycle; held command during ARMED.
        sendCmd(3'd1, 9'h055);
        vSync = 1'b0;
        tick();  // E0: frameTick now high
        cmdValid = 1'b1;
        cmdOp    = 3'd6;
        cmdData  = 9'h000;
        tick();  // accepted while IDLE
        cmdOp   = 3'd1;
        cmdData = 9'h1FF;
        check("sametick pending", 32'(pending), 32'd1);
        tick();
        vSync = 1'b1;
        repeat (5) tick();
        check("sametick no commit", 32'(charRGB), 32'h1FF);
        check("held cmdReady", 32'(cmdReady), 32'd0);
        vSync = 1'b0;
        tick();
        tick();
        check("next E1 charRGB", 32'(charRGB), 32'h1FF);
        tick();
        check("next E2 charRGB", 32'(charRGB), 32'h055);
        check("next E2 cmdReady", 32'(cmdReady), 32'd1);
        tick();  // held op1 accepted here
        cmdValid = 1'b0;
        vSync    = 1'b1;
        repeat (6) tick();
        check("held not live", 32'(charRGB), 32'h055);
        sendCmd(3'd6, 9'h000);
        frame();
        check("held committed", 32'(charRGB), 32'h1FF);

        // Reset while ARMED discards the pending commit.
        sendCmd(3'd2, 9'h0AA);
        sendCmd(3'd6, 9'h000);
        frame();
        check("pre-reset bgRGB", 32'(bgRGB), 32'h0AA);
        sendCmd(3'd1, 9'h100);
        sendCmd(3'd6, 9'h000);
        check("pre-reset pending", 32'(pending), 32'd1);
        reset = 1'b1;
        #1;
        checkLive("async reset", 9'h1FF, 9'h000, 4'd1, 4'd0);
        check("async reset pending", 32'(pending), 32'd0);
        check("async reset cmdReady", 32'(cmdReady), 32'd1);
        tick();
        reset = 1'b0;
        frame();
        frame();
        checkLive("post-reset", 9'h1FF, 9'h000, 4'd1, 4'd0);
        check("post-reset pending", 32'(pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
